perf_report_sched: RTL

Periodic report scheduler for the cache-event monitor path. It owns eight 32-bit event counters and snapshots them at a fixed interval. It then sequences each snapshot as a 10-word frame (header, 8 counts, checksum) into the word-to-byte serializer that feeds the UART transmitter. It paces itself on the serializer's ready signal so no word is issued while the byte/UART path is busy.

---
 rtl/perf_report_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/perf_report_sched.sv
// Periodic cache-event report scheduler: eight saturating 32-bit counters, snapshot every PERIOD cycles.
// Latency: a tick at cycle T raises busy_o at T+1, and the first word can pulse at T+1 when ready is high.
// Backpressure: SEND waits on word_ready_i, and HOLD ignores ready for one cycle; ticks during a frame are recorded as missed.
module perf_report_sched #(
   parameter int unsigned PERIOD  = 100000,
   parameter logic [7:0]  HDR_TAG = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  ev_i,
   input  logic        enable_i,
   input  logic        word_ready_i,
   output logic [31:0] word_o,
   output logic        word_valid_o,
   output logic        busy_o,
   output logic [7:0]  seq_o
);

   localparam int unsigned    TW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [TW-1:0]  TLAST = TW'(PERIOD - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_HOLD
   } state_t;

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic [31:0]   r_cnt    [8];
   logic [31:0]   r_shadow [8];
   logic [7:0]    r_sat;
   logic          r_missed;
   logic [7:0]    r_seq;
   logic [3:0]    r_idx;
   logic [31:0]   r_word;
   logic [31:0]   r_csum;

   logic          w_tick;
   logic          w_start;
   logic          w_issue;
   logic [31:0]   w_hdr;
   logic [31:0]   w_next_word;
   logic [3:0]    w_next_idx;

   assign w_tick  = enable_i && (r_timer == TLAST);
   assign w_start = w_tick && (r_state == S_IDLE);
   // The valid pulse follows the live ready so that a word can go out in the first SEND cycle.
   assign w_issue = (r_state == S_SEND) && word_ready_i;
   assign w_hdr   = {HDR_TAG, r_seq, r_sat, 7'b0, r_missed};

   // Word that follows index r_idx: shadow[r_idx] for frame positions 1..8, and the checksum after the last count.
   assign w_next_idx  = r_idx + 4'd1;
   assign w_next_word = (r_idx == 4'd8) ? r_csum : r_shadow[r_idx[2:0]];

   assign word_o       = r_word;
   assign word_valid_o = w_issue;
   assign busy_o       = (r_state != S_IDLE);
   assign seq_o        = r_seq;

   // Interval timer: runs only while enabled, and is held at zero otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_timer <= '0;
      end else if (!enable_i || (r_timer == TLAST)) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + 1'b1;
      end
   end

   // Live counters with sticky saturation. At a snapshot, the tick-cycle event starts the new interval.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat <= '0;
         for (int k = 0; k < 8; k++) begin
            r_cnt[k]    <= '0;
            r_shadow[k] <= '0;
         end
      end else if (w_start) begin
         r_sat <= '0;
         for (int k = 0; k < 8; k++) begin
            r_shadow[k] <= r_cnt[k];
            r_cnt[k]    <= {31'b0, ev_i[k]};
         end
      end else if (enable_i) begin
         for (int k = 0; k < 8; k++) begin
            if (ev_i[k]) begin
               if (r_cnt[k] != 32'hFFFF_FFFF) begin
                  r_cnt[k] <= r_cnt[k] + 32'd1;
               end
               // Set when the count reaches the ceiling, or when it is already held there.
               if (r_cnt[k] >= 32'hFFFF_FFFE) begin
                  r_sat[k] <= 1'b1;
               end
            end
         end
      end
   end

   // Frame sequencer: preload each word on entry to SEND, so word_o is stable through the pulse and the HOLD cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_word   <= '0;
         r_csum   <= '0;
         r_seq    <= '0;
         r_missed <= 1'b0;
      end else begin
         if (w_tick && (r_state != S_IDLE)) begin
            r_missed <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_tick) begin
                  r_word   <= w_hdr;
                  r_csum   <= '0;
                  r_idx    <= '0;
                  r_missed <= 1'b0;
                  r_state  <= S_SEND;
               end
            end
            S_SEND: begin
               if (word_ready_i) begin
                  r_csum  <= r_csum ^ r_word;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (r_idx == 4'd9) begin
                  r_seq   <= r_seq + 8'd1;
                  r_state <= S_IDLE;
               end else begin
                  r_idx   <= w_next_idx;
                  r_word  <= w_next_word;
                  r_state <= S_SEND;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
